// File: rtl/conv_pool_layer.sv
// Multi-channel TAPS-cycle MAC with bias, shift and ReLU into a feature-map RAM, plus concurrent
// 2x2/stride-2 max pooling streamed over valid/ready. Optional macro: CONV_POOL_SAT_EN.
module conv_pool_layer #(
  parameter int DATA_W = 18,
  parameter int W_W    = 9,
  parameter int IN_CH  = 2,
  parameter int OUT_CH = 4,
  parameter int TAPS   = 10,
  parameter int MAP_W  = 11,
  parameter int MAP_H  = 11,
  parameter int SHIFT  = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          strt,
  input  logic [IN_CH*DATA_W-1:0]       din,
  output logic [$clog2(TAPS)-1:0]       w_addr,
  input  logic [OUT_CH*IN_CH*W_W-1:0]   w_data,
  input  logic [OUT_CH*W_W-1:0]         bias,
  output logic                          bsy,
  output logic [DATA_W-1:0]             dout,
  output logic                          dout_vld,
  input  logic                          dout_rdy,
  output logic                          ovf,
  output logic                          frame_done
);
  localparam int ACC_W  = DATA_W + W_W + $clog2(TAPS*IN_CH) + 1;
  localparam int DEPTH  = MAP_H * MAP_W;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = $clog2(DEPTH + 1);
  localparam int AW     = $clog2(TAPS);
  localparam int WIN_W  = MAP_W / 2;
  localparam int WIN_H  = MAP_H / 2;
  localparam int WC_W   = $clog2(WIN_W + 1);
  localparam int WR_W   = $clog2(WIN_H + 1);
  localparam int CH_W   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(2 * MAP_W);
`ifdef CONV_POOL_SAT_EN
  localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
`endif

  typedef enum logic [1:0] {WR_IDLE, WR_ACC, WR_WRITE} wr_state_t;
  typedef enum logic [2:0] {RD_IDLE, RD_FETCH0, RD_FETCH1, RD_FETCH2, RD_FETCH3, RD_POOL, RD_EMIT} rd_state_t;

  wr_state_t               wr_state_r;
  rd_state_t               rd_state_r;
  logic [AW-1:0]           tap_r;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic signed [ACC_W-1:0] acc_r     [OUT_CH];
  logic signed [ACC_W-1:0] tap_sum_s [OUT_CH];
  logic [DATA_W-1:0]       res_s     [OUT_CH];
  logic [DATA_W-1:0]       mem_r     [OUT_CH][DEPTH];
  logic [DATA_W-1:0]       rd_q_r    [OUT_CH];
  logic [DATA_W-1:0]       max_r     [OUT_CH];
  logic [ADDR_W-1:0]       base_r, row_base_r, rd_addr_s;
  logic [WC_W-1:0]         win_c_r;
  logic [WR_W-1:0]         win_r_r;
  logic [CH_W-1:0]         ch_r;
  logic                    ready_s, last_col_s, last_row_s, frame_end_s;

  function automatic logic signed [ACC_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [W_W-1:0] w);
    logic signed [ACC_W-1:0] ae;
    logic signed [ACC_W-1:0] we;
    ae = ACC_W'(a);
    we = ACC_W'(w);
    return ae * we;
  endfunction

  function automatic logic [DATA_W-1:0] post_act(input logic signed [ACC_W-1:0] acc,
                                                 input logic signed [W_W-1:0] b);
    logic signed [ACC_W-1:0] v;
    v = (acc + ACC_W'(b)) >>> SHIFT;
    if (v[ACC_W-1] || (v == '0)) return '0;
`ifdef CONV_POOL_SAT_EN
    else if (v > POS_MAX) return POS_MAX[DATA_W-1:0];
`endif
    else return v[DATA_W-1:0];
  endfunction

  // Stored values are post-ReLU, so pooling orders them by raw bits (keeps wrapped values ordered)
  function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (a > b) return a;
    else return b;
  endfunction

  // Per-channel tap products and the finished pixel value
  always_comb begin
    for (int ch = 0; ch < OUT_CH; ch++) begin
      tap_sum_s[ch] = '0;
      for (int i = 0; i < IN_CH; i++) begin
        tap_sum_s[ch] = tap_sum_s[ch] + mul_ext(din[i*DATA_W +: DATA_W], w_data[(ch*IN_CH+i)*W_W +: W_W]);
      end
      res_s[ch] = post_act(acc_r[ch], bias[ch*W_W +: W_W]);
    end
  end

  // Window readiness, frame end and pooling read address
  always_comb begin
    ready_s     = (wr_ptr_r > (PTR_W'(base_r) + PTR_W'(MAP_W + 1)));
    last_col_s  = (win_c_r == WC_W'(WIN_W - 1));
    last_row_s  = (win_r_r == WR_W'(WIN_H - 1));
    frame_end_s = (rd_state_r == RD_EMIT) && dout_rdy && (ch_r == CH_W'(OUT_CH - 1)) && last_col_s && last_row_s;
    case (rd_state_r)
      RD_FETCH0: rd_addr_s = base_r;
      RD_FETCH1: rd_addr_s = base_r + ADDR_W'(1);
      RD_FETCH2: rd_addr_s = base_r + ADDR_W'(MAP_W);
      RD_FETCH3: rd_addr_s = base_r + ADDR_W'(MAP_W + 1);
      default:   rd_addr_s = base_r;
    endcase
  end

  // Write FSM: accumulate TAPS cycles, then commit one pixel per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_r <= WR_IDLE;
      wr_ptr_r   <= '0;
      tap_r      <= '0;
      w_addr     <= '0;
      bsy        <= 1'b0;
      ovf        <= 1'b0;
      for (int ch = 0; ch < OUT_CH; ch++) acc_r[ch] <= '0;
    end else if (clr || frame_end_s) begin
      wr_state_r <= WR_IDLE;
      wr_ptr_r   <= '0;
      tap_r      <= '0;
      w_addr     <= '0;
      bsy        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (wr_state_r)
        WR_IDLE: begin
          if (strt && (wr_ptr_r < PTR_W'(DEPTH))) begin
            for (int ch = 0; ch < OUT_CH; ch++) acc_r[ch] <= '0;
            tap_r      <= '0;
            w_addr     <= AW'(1);
            bsy        <= 1'b1;
            wr_state_r <= WR_ACC;
          end else if (strt) begin
            ovf <= 1'b1;
          end
        end
        WR_ACC: begin
          for (int ch = 0; ch < OUT_CH; ch++) acc_r[ch] <= acc_r[ch] + tap_sum_s[ch];
          if (tap_r == AW'(TAPS - 1)) begin
            w_addr     <= '0;
            wr_state_r <= WR_WRITE;
          end else begin
            tap_r  <= tap_r + AW'(1);
            w_addr <= tap_r + AW'(2);
          end
        end
        WR_WRITE: begin
          wr_ptr_r   <= wr_ptr_r + PTR_W'(1);
          bsy        <= 1'b0;
          wr_state_r <= WR_IDLE;
        end
        default: wr_state_r <= WR_IDLE;
      endcase
    end
  end

  // Feature-map RAM: one bank per channel, synchronous write and read ports
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < OUT_CH; ch++) begin
      if ((wr_state_r == WR_WRITE) && !clr) mem_r[ch][wr_ptr_r[ADDR_W-1:0]] <= res_s[ch];
      rd_q_r[ch] <= mem_r[ch][rd_addr_s];
    end
  end

  // Read FSM: fetch a ready 2x2 window, pool it, stream channels out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_r <= RD_IDLE;
      base_r     <= '0;
      row_base_r <= '0;
      win_c_r    <= '0;
      win_r_r    <= '0;
      ch_r       <= '0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      frame_done <= 1'b0;
      for (int ch = 0; ch < OUT_CH; ch++) max_r[ch] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (clr) begin
        rd_state_r <= RD_IDLE;
        base_r     <= '0;
        row_base_r <= '0;
        win_c_r    <= '0;
        win_r_r    <= '0;
        ch_r       <= '0;
        dout_vld   <= 1'b0;
      end else begin
        case (rd_state_r)
          RD_IDLE:   if (ready_s) rd_state_r <= RD_FETCH0;
          RD_FETCH0: rd_state_r <= RD_FETCH1;
          RD_FETCH1: begin
            for (int ch = 0; ch < OUT_CH; ch++) max_r[ch] <= rd_q_r[ch];
            rd_state_r <= RD_FETCH2;
          end
          RD_FETCH2, RD_FETCH3: begin
            for (int ch = 0; ch < OUT_CH; ch++) max_r[ch] <= umax(max_r[ch], rd_q_r[ch]);
            rd_state_r <= (rd_state_r == RD_FETCH2) ? RD_FETCH3 : RD_POOL;
          end
          RD_POOL: begin
            for (int ch = 0; ch < OUT_CH; ch++) max_r[ch] <= umax(max_r[ch], rd_q_r[ch]);
            dout       <= umax(max_r[0], rd_q_r[0]);
            dout_vld   <= 1'b1;
            ch_r       <= '0;
            rd_state_r <= RD_EMIT;
          end
          RD_EMIT: begin
            if (dout_rdy && (ch_r == CH_W'(OUT_CH - 1))) begin
              dout_vld   <= 1'b0;
              rd_state_r <= RD_IDLE;
              if (last_col_s && last_row_s) begin
                frame_done <= 1'b1;
                base_r     <= '0;
                row_base_r <= '0;
                win_c_r    <= '0;
                win_r_r    <= '0;
              end else if (last_col_s) begin
                base_r     <= row_base_r + ROW_STEP;
                row_base_r <= row_base_r + ROW_STEP;
                win_c_r    <= '0;
                win_r_r    <= win_r_r + WR_W'(1);
              end else begin
                base_r  <= base_r + ADDR_W'(2);
                win_c_r <= win_c_r + WC_W'(1);
              end
            end else if (dout_rdy) begin
              ch_r <= ch_r + CH_W'(1);
              dout <= max_r[ch_r + CH_W'(1)];
            end
          end
          default: rd_state_r <= RD_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_conv_pool_layer.sv
// Scoreboard bench for conv_pool_layer on a 4x4 map: expected pooled values are queued per frame
// and a negedge monitor pops and compares on every accepted dout.
module tb_conv_pool_layer;
  localparam int DATA_W = 18, W_W = 9, IN_CH = 2, OUT_CH = 4, TAPS = 10, MAP_W = 4, MAP_H = 4;
  localparam int AW = $clog2(TAPS);
  localparam int VALS_PER_FRAME = OUT_CH * (MAP_W / 2) * (MAP_H / 2);

  logic                        clk = 1'b0;
  logic                        rst, clr, strt, dout_rdy;
  logic [IN_CH*DATA_W-1:0]     din;
  logic [AW-1:0]               w_addr;
  logic [OUT_CH*IN_CH*W_W-1:0] w_data;
  logic [OUT_CH*W_W-1:0]       bias;
  logic                        bsy, dout_vld, ovf, frame_done;
  logic [DATA_W-1:0]           dout;

  int rom_w [16];
  logic [DATA_W-1:0] exp_q [$];
  int errors = 0, checks = 0;
  int acc_cnt = 0, frame_acc = 0, fd_cnt = 0, px_done = 0;

  always #5 clk = ~clk;

  conv_pool_layer #(.DATA_W(DATA_W), .W_W(W_W), .IN_CH(IN_CH), .OUT_CH(OUT_CH), .TAPS(TAPS),
                    .MAP_W(MAP_W), .MAP_H(MAP_H), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .strt(strt), .din(din), .w_addr(w_addr), .w_data(w_data),
    .bias(bias), .bsy(bsy), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .ovf(ovf),
    .frame_done(frame_done));

  // Synchronous weight ROM: one scalar weight per tap, replicated over every channel/lane
  always @(posedge clk) begin
    for (int j = 0; j < OUT_CH*IN_CH; j++)
      w_data[j*W_W +: W_W] <= (int'(w_addr) < TAPS) ? W_W'(rom_w[w_addr]) : '0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input int a, input int b, input int c, input int d);
    exp_q.push_back(DATA_W'(a));
    exp_q.push_back(DATA_W'(b));
    exp_q.push_back(DATA_W'(c));
    exp_q.push_back(DATA_W'(d));
  endtask

  // One pixel: lanes (a, b) on tap tap_sel only, or on every tap when tap_sel < 0
  task automatic do_pixel(input int a, input int b, input int tap_sel, output int nbsy, output int wa0);
    int g;
    strt = 1'b1;
    din  = '0;
    tick();
    strt = 1'b0;
    nbsy = 0;
    wa0  = int'(w_addr);
    for (int k = 0; k < TAPS; k++) begin
      if (tap_sel < 0 || tap_sel == k) din = {DATA_W'(b), DATA_W'(a)};
      else din = '0;
      if (bsy) nbsy++;
      tick();
    end
    din = '0;
    g = 0;
    while (bsy && g < 20) begin
      nbsy++;
      g++;
      tick();
    end
    px_done++;
  endtask

  // Monitor: compare accepted outputs, hold stability under backpressure, frame_done placement
  initial begin : monitor
    logic stall, fd_prev, first_seen;
    logic [DATA_W-1:0] held;
    stall = 1'b0; fd_prev = 1'b0; first_seen = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (rst || clr) begin
        stall = 1'b0; fd_prev = 1'b0; frame_acc = 0;
      end else begin
        if (stall) begin
          check("hold_vld", dout_vld, 1);
          check("hold_dout", dout, held);
        end
        if (dout_vld && !first_seen) begin
          first_seen = 1'b1;
          check("first_vld_after_px5", px_done >= 6, 1);
        end
        if (dout_vld && dout_rdy) begin
          if (exp_q.size() == 0) check("unexpected_dout", 1, 0);
          else check("dout", dout, exp_q.pop_front());
          acc_cnt++;
          frame_acc++;
        end
        stall = dout_vld && !dout_rdy;
        held  = dout;
        if (frame_done) begin
          check("frame_done_after_all", frame_acc, VALS_PER_FRAME);
          check("frame_done_pulse", fd_prev, 0);
          fd_cnt++;
          frame_acc = 0;
        end
        fd_prev = frame_done;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, wa, g, e0, e2;
    rst = 1'b1; clr = 1'b0; strt = 1'b0; din = '0; dout_rdy = 1'b0; bias = '0;
    for (int k = 0; k < 16; k++) rom_w[k] = (k < TAPS) ? 1 : 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_bsy", bsy, 0);
    check("rst_vld", dout_vld, 0);
    check("rst_ovf", ovf, 0);
    check("rst_fd", frame_done, 0);
    check("rst_waddr", w_addr, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
    tick();

    // Frame A: pixel p stores p on every channel; windows max to 5, 7, 13, 15
    push4(5, 5, 5, 5); push4(7, 7, 7, 7); push4(13, 13, 13, 13); push4(15, 15, 15, 15);
    for (int p = 0; p < 16; p++) do_pixel(p, 0, 0, n, wa);
    strt = 1'b1;
    tick();
    strt = 1'b0;
    check("ovf_on_full", ovf, 1);
    check("full_strt_no_bsy", bsy, 0);
    tick();
    check("full_strt_no_bsy2", bsy, 0);
    dout_rdy = 1'b1;
    g = 0;
    while (acc_cnt < 5 && g < 300) begin tick(); g++; end
    dout_rdy = 1'b0;
    repeat (7) tick();
    dout_rdy = 1'b1;
    g = 0;
    while (fd_cnt < 1 && g < 300) begin tick(); g++; end
    check("frame_a_done", fd_cnt, 1);
    tick();
    check("ovf_cleared", ovf, 0);

    // Frame B: bias -5 on channel 2; 30-sum, bias/ReLU, overflow and negative pixels
`ifdef CONV_POOL_SAT_EN
    e0 = 131071; e2 = 131071;
`else
    e0 = 131077; e2 = 131072;   // low 18 bits of 2^17+5 and 2^17
`endif
    bias = {9'd0, 9'h1FB, 9'd0, 9'd0};
    push4(30, 30, 25, 30); push4(3, 3, 0, 3); push4(e0, e0, e2, e0); push4(0, 0, 0, 0);
    for (int p = 0; p < 16; p++) begin
      case (p)
        0: begin
          do_pixel(1, 2, -1, n, wa);
          check("bsy_cycles", n, 11);
          check("w_addr_acc0", wa, 1);
        end
        2:       do_pixel(3, 0, 0, n, wa);
        8:       do_pixel(131071, 6, 0, n, wa);
        10:      do_pixel(-100, 50, 0, n, wa);
        default: do_pixel(0, 0, 0, n, wa);
      endcase
    end
    g = 0;
    while (fd_cnt < 2 && g < 300) begin tick(); g++; end
    check("frame_b_done", fd_cnt, 2);

    // Frame C: ramp weights, partial frame discarded by clr coinciding with strt
    bias = '0;
    for (int k = 0; k < TAPS; k++) rom_w[k] = k + 1;
    for (int p = 0; p < 3; p++) do_pixel(200, 0, 0, n, wa);
    clr  = 1'b1;
    strt = 1'b1;
    tick();
    clr  = 1'b0;
    strt = 1'b0;
    check("clr_strt_bsy", bsy, 0);
    check("clr_vld", dout_vld, 0);
    check("clr_ovf", ovf, 0);
    tick();
    check("clr_strt_bsy2", bsy, 0);
    push4(55, 55, 55, 55);
    for (int p = 0; p < 6; p++) begin
      if (p == 4) do_pixel(1, 0, -1, n, wa);
      else do_pixel(0, 0, 0, n, wa);
    end
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin tick(); g++; end
    check("queue_drained", exp_q.size(), 0);
    check("no_extra_frame_done", fd_cnt, 2);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
